// File: rtl/program_loader_if.sv
// Byte-stream and instruction-memory port bundle between the program loader
// and its surroundings (UART RX, pipeline fetch and instruction memory).
interface program_loader_if;
  logic [7:0]  i_rx_data;
  logic        i_rx_valid;
  logic        i_program_end;
  logic        o_write_instruction_mem;
  logic [31:0] o_instruction_mem_addr;
  logic [31:0] o_instruction_mem_data;
  logic        o_halt;
  logic        o_loaded;
  logic        o_running;
  logic        o_done;
  logic        o_error;

  // Loader side: consumes bytes and program_end, drives memory port and status.
  modport master (
    input  i_rx_data,
    input  i_rx_valid,
    input  i_program_end,
    output o_write_instruction_mem,
    output o_instruction_mem_addr,
    output o_instruction_mem_data,
    output o_halt,
    output o_loaded,
    output o_running,
    output o_done,
    output o_error
  );

  // Environment side: byte source, pipeline and instruction memory.
  modport slave (
    output i_rx_data,
    output i_rx_valid,
    output i_program_end,
    input  o_write_instruction_mem,
    input  o_instruction_mem_addr,
    input  o_instruction_mem_data,
    input  o_halt,
    input  o_loaded,
    input  o_running,
    input  o_done,
    input  o_error
  );
endinterface

// File: rtl/program_loader.sv
// Fills instruction memory from a big-endian byte stream and gates pipeline
// fetch with run / single-step commands. All outputs are registered.
module program_loader #(
  parameter int unsigned INSTR_MEM_DEPTH = 256,
  parameter logic [31:0] HALT_WORD       = 32'hFFFF_FFFF,
  parameter logic [7:0]  CMD_LOAD        = 8'h4C,
  parameter logic [7:0]  CMD_RUN         = 8'h52,
  parameter logic [7:0]  CMD_STEP        = 8'h53
) (
  input  logic              i_clk,
  input  logic              i_reset,
  program_loader_if.master  bus
);

  localparam int unsigned         IDX_W    = (INSTR_MEM_DEPTH > 1) ? $clog2(INSTR_MEM_DEPTH) : 1;
  localparam logic [IDX_W-1:0]    LAST_IDX = IDX_W'(INSTR_MEM_DEPTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_RUN  = 2'd2,
    S_STEP = 2'd3
  } state_t;

  state_t           state_q;
  logic [1:0]       byte_cnt_q;
  logic [IDX_W-1:0] index_q;
  logic [23:0]      shift_q;
  logic             we_q;
  logic [31:0]      addr_q;
  logic [31:0]      data_q;
  logic             halt_q;
  logic             loaded_q;
  logic             running_q;
  logic             done_q;
  logic             error_q;
  logic [31:0]      word_d;

  // The three earlier bytes sit in shift_q; the current byte completes the word.
  always_comb begin
    word_d = {shift_q, bus.i_rx_data};
  end

  // Loader FSM with registered memory-port and status outputs.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state_q    <= S_IDLE;
      byte_cnt_q <= 2'd0;
      index_q    <= '0;
      shift_q    <= 24'd0;
      we_q       <= 1'b0;
      addr_q     <= 32'd0;
      data_q     <= 32'd0;
      halt_q     <= 1'b1;
      loaded_q   <= 1'b0;
      running_q  <= 1'b0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
    end else begin
      we_q   <= 1'b0;
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (bus.i_rx_valid) begin
            if (bus.i_rx_data == CMD_LOAD) begin
              state_q    <= S_LOAD;
              byte_cnt_q <= 2'd0;
              index_q    <= '0;
              loaded_q   <= 1'b0;
              error_q    <= 1'b0;
            end else if ((bus.i_rx_data == CMD_RUN) && loaded_q) begin
              state_q   <= S_RUN;
              halt_q    <= 1'b0;
              running_q <= 1'b1;
            end else if ((bus.i_rx_data == CMD_STEP) && loaded_q) begin
              state_q <= S_STEP;
              halt_q  <= 1'b0;
            end else begin
              state_q <= S_IDLE;
            end
          end
        end
        S_LOAD: begin
          // Command byte values are plain data here.
          if (bus.i_rx_valid) begin
            byte_cnt_q <= byte_cnt_q + 2'd1;
            shift_q    <= {shift_q[15:0], bus.i_rx_data};
            if (byte_cnt_q == 2'd3) begin
              we_q    <= 1'b1;
              addr_q  <= {30'(index_q), 2'b00};
              data_q  <= word_d;
              index_q <= index_q + IDX_W'(1);
              if (word_d == HALT_WORD) begin
                loaded_q <= 1'b1;
                state_q  <= S_IDLE;
              end else if (index_q == LAST_IDX) begin
                error_q  <= 1'b1;
                loaded_q <= 1'b0;
                state_q  <= S_IDLE;
              end else begin
                state_q <= S_LOAD;
              end
            end
          end
        end
        S_RUN: begin
          if (bus.i_program_end) begin
            halt_q    <= 1'b1;
            running_q <= 1'b0;
            done_q    <= 1'b1;
            state_q   <= S_IDLE;
          end
        end
        S_STEP: begin
          // Fetch was released for exactly this one cycle.
          halt_q  <= 1'b1;
          done_q  <= bus.i_program_end;
          state_q <= S_IDLE;
        end
        default: begin
          state_q   <= S_IDLE;
          halt_q    <= 1'b1;
          running_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.o_write_instruction_mem = we_q;
  assign bus.o_instruction_mem_addr  = addr_q;
  assign bus.o_instruction_mem_data  = data_q;
  assign bus.o_halt                  = halt_q;
  assign bus.o_loaded                = loaded_q;
  assign bus.o_running               = running_q;
  assign bus.o_done                  = done_q;
  assign bus.o_error                 = error_q;

endmodule

// File: tb/tb_program_loader.sv
// Bench for program_loader: table-driven program loads with a write scoreboard,
// plus hand-written run, step, reset-mid-load and overflow sequences.
module tb_program_loader;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  program_loader_if ifa();
  program_loader_if ifb();

  program_loader dut_a (.i_clk(clk), .i_reset(rst_n), .bus(ifa));
  program_loader #(.INSTR_MEM_DEPTH(4)) dut_b (.i_clk(clk), .i_reset(rst_n), .bus(ifb));

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  typedef struct {
    logic [31:0] word;
    logic [31:0] addr;
  } vec_t;

  int   errors = 0;
  int   checks = 0;
  wr_t  qa[$];
  wr_t  qb[$];
  vec_t prog[3];
  vec_t ovf[4];
  logic prev_a = 1'b0;
  logic prev_b = 1'b0;
  int   strobes_a = 0;
  int   strobes_b = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input int sel, input logic [7:0] b);
    if (sel == 0) begin
      ifa.i_rx_data  = b;
      ifa.i_rx_valid = 1'b1;
    end else begin
      ifb.i_rx_data  = b;
      ifb.i_rx_valid = 1'b1;
    end
    @(posedge clk);
    #1;
    ifa.i_rx_valid = 1'b0;
    ifb.i_rx_valid = 1'b0;
  endtask

  task automatic load_word(input int sel, input logic [31:0] word, input logic [31:0] addr,
                           input int gap);
    wr_t w;
    logic [7:0] b;
    w.addr = addr;
    w.data = word;
    if (sel == 0) qa.push_back(w);
    else          qb.push_back(w);
    for (int i = 0; i < 4; i++) begin
      b = word[31-8*i -: 8];
      send(sel, b);
      if (i == 3) begin
        if (sel == 0) check("a_write_latency", 32'(ifa.o_write_instruction_mem), 32'd1);
        else          check("b_write_latency", 32'(ifb.o_write_instruction_mem), 32'd1);
      end
      idle(gap);
    end
  endtask

  task automatic check_reset_a(input string tag);
    check({tag, "_halt"},    32'(ifa.o_halt), 32'd1);
    check({tag, "_we"},      32'(ifa.o_write_instruction_mem), 32'd0);
    check({tag, "_addr"},    ifa.o_instruction_mem_addr, 32'd0);
    check({tag, "_data"},    ifa.o_instruction_mem_data, 32'd0);
    check({tag, "_loaded"},  32'(ifa.o_loaded), 32'd0);
    check({tag, "_running"}, 32'(ifa.o_running), 32'd0);
    check({tag, "_done"},    32'(ifa.o_done), 32'd0);
    check({tag, "_error"},   32'(ifa.o_error), 32'd0);
  endtask

  // Write scoreboard for the default-depth loader.
  always @(negedge clk) begin
    wr_t w;
    if (ifa.o_write_instruction_mem) begin
      strobes_a++;
      check("a_strobe_single_cycle", 32'(prev_a), 32'd0);
      check("a_halt_during_write", 32'(ifa.o_halt), 32'd1);
      if (qa.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL a_unexpected_write: got addr %h data %h expected no write",
                 ifa.o_instruction_mem_addr, ifa.o_instruction_mem_data);
      end else begin
        w = qa.pop_front();
        check("a_write_addr", ifa.o_instruction_mem_addr, w.addr);
        check("a_write_data", ifa.o_instruction_mem_data, w.data);
      end
    end
    prev_a = ifa.o_write_instruction_mem;
  end

  // Write scoreboard for the depth-4 loader.
  always @(negedge clk) begin
    wr_t w;
    if (ifb.o_write_instruction_mem) begin
      strobes_b++;
      check("b_strobe_single_cycle", 32'(prev_b), 32'd0);
      check("b_halt_during_write", 32'(ifb.o_halt), 32'd1);
      if (qb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL b_unexpected_write: got addr %h data %h expected no write",
                 ifb.o_instruction_mem_addr, ifb.o_instruction_mem_data);
      end else begin
        w = qb.pop_front();
        check("b_write_addr", ifb.o_instruction_mem_addr, w.addr);
        check("b_write_data", ifb.o_instruction_mem_data, w.data);
      end
    end
    prev_b = ifb.o_write_instruction_mem;
  end

  initial begin
    prog[0] = '{word: 32'h0000_0001, addr: 32'h0000_0000};
    prog[1] = '{word: 32'h2001_0005, addr: 32'h0000_0004};
    prog[2] = '{word: 32'hFFFF_FFFF, addr: 32'h0000_0008};
    ovf[0]  = '{word: 32'h1111_1111, addr: 32'h0000_0000};
    ovf[1]  = '{word: 32'h2222_2222, addr: 32'h0000_0004};
    ovf[2]  = '{word: 32'h3333_3333, addr: 32'h0000_0008};
    ovf[3]  = '{word: 32'h4C52_5344, addr: 32'h0000_000C};

    ifa.i_rx_data = 8'h00; ifa.i_rx_valid = 1'b0; ifa.i_program_end = 1'b0;
    ifb.i_rx_data = 8'h00; ifb.i_rx_valid = 1'b0; ifb.i_program_end = 1'b0;
    rst_n = 1'b0;
    idle(2);
    check_reset_a("rst");
    check("rst_b_halt", 32'(ifb.o_halt), 32'd1);
    check("rst_b_error", 32'(ifb.o_error), 32'd0);
    rst_n = 1'b1;
    idle(1);

    // RUN / STEP before any load are ignored.
    send(0, 8'h52);
    check("preload_run_halt", 32'(ifa.o_halt), 32'd1);
    check("preload_run_running", 32'(ifa.o_running), 32'd0);
    send(0, 8'h53);
    check("preload_step_halt", 32'(ifa.o_halt), 32'd1);
    idle(1);
    check("preload_step_halt2", 32'(ifa.o_halt), 32'd1);

    // Gapped load.
    send(0, 8'h4C);
    idle(1);
    for (int i = 0; i < 3; i++) begin
      load_word(0, prog[i].word, prog[i].addr, 1);
      check("load_halt_held", 32'(ifa.o_halt), 32'd1);
    end
    idle(2);
    check("load_write_count", 32'(strobes_a), 32'd3);
    check("load_loaded", 32'(ifa.o_loaded), 32'd1);

    // Back-to-back reload.
    send(0, 8'h4C);
    for (int i = 0; i < 3; i++) load_word(0, prog[i].word, prog[i].addr, 0);
    idle(2);
    check("b2b_write_count", 32'(strobes_a), 32'd6);
    check("b2b_loaded", 32'(ifa.o_loaded), 32'd1);

    // Run until program_end.
    send(0, 8'h52);
    check("run_halt_low", 32'(ifa.o_halt), 32'd0);
    check("run_running", 32'(ifa.o_running), 32'd1);
    send(0, 8'h4C);
    idle(2);
    check("run_ignores_bytes", 32'(ifa.o_running), 32'd1);
    check("run_halt_still_low", 32'(ifa.o_halt), 32'd0);
    ifa.i_program_end = 1'b1;
    idle(1);
    check("run_end_halt", 32'(ifa.o_halt), 32'd1);
    check("run_end_done", 32'(ifa.o_done), 32'd1);
    check("run_end_running", 32'(ifa.o_running), 32'd0);
    ifa.i_program_end = 1'b0;
    idle(1);
    check("run_done_pulse_once", 32'(ifa.o_done), 32'd0);
    check("run_idle_halt", 32'(ifa.o_halt), 32'd1);

    // Three single steps; the last one sees program_end.
    for (int k = 0; k < 3; k++) begin
      ifa.i_program_end = (k == 2);
      send(0, 8'h53);
      check("step_halt_low", 32'(ifa.o_halt), 32'd0);
      check("step_done_early", 32'(ifa.o_done), 32'd0);
      idle(1);
      check("step_halt_back", 32'(ifa.o_halt), 32'd1);
      check("step_done", 32'(ifa.o_done), 32'(k == 2));
      ifa.i_program_end = 1'b0;
      idle(1);
      check("step_halt_gap", 32'(ifa.o_halt), 32'd1);
    end

    // Reset after two bytes of a word.
    send(0, 8'h4C);
    send(0, 8'hAB);
    send(0, 8'hCD);
    rst_n = 1'b0;
    #2;
    check_reset_a("midrst");
    idle(2);
    rst_n = 1'b1;
    idle(1);
    check_reset_a("postrst");
    check("midrst_no_write", 32'(strobes_a), 32'd6);
    send(0, 8'h4C);
    load_word(0, 32'h0000_0007, 32'h0000_0000, 1);
    load_word(0, 32'hFFFF_FFFF, 32'h0000_0004, 1);
    idle(2);
    check("reload_write_count", 32'(strobes_a), 32'd8);
    check("reload_loaded", 32'(ifa.o_loaded), 32'd1);

    // Overflow on the depth-4 loader.
    send(1, 8'h4C);
    for (int i = 0; i < 4; i++) load_word(1, ovf[i].word, ovf[i].addr, 1);
    idle(1);
    check("ovf_write_count", 32'(strobes_b), 32'd4);
    check("ovf_error", 32'(ifb.o_error), 32'd1);
    check("ovf_loaded", 32'(ifb.o_loaded), 32'd0);
    send(1, 8'h52);
    check("ovf_run_halt", 32'(ifb.o_halt), 32'd1);
    check("ovf_run_running", 32'(ifb.o_running), 32'd0);
    idle(2);
    check("ovf_error_sticky", 32'(ifb.o_error), 32'd1);
    check("ovf_no_extra_write", 32'(strobes_b), 32'd4);

    check("a_queue_empty", 32'(qa.size()), 32'd0);
    check("b_queue_empty", 32'(qb.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
